// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_I = 4'd2,
      S_EXEC_B = 4'd3,
      S_EXEC_M = 4'd4,
      S_MEM_RD = 4'd5,
      S_MEM_WR = 4'd6,
      S_WB     = 4'd7,
      S_TRAP   = 4'd8
   } state_e;

   localparam logic [4:0] OP_OPIMM  = 5'b00100;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_WORD = 3'b010;

   typedef enum logic [2:0] {ALU_ADD = 3'd0, ALU_SUB = 3'd1} alu_op_e;
   typedef enum logic [1:0] {IMM_I = 2'd0, IMM_S = 2'd1, IMM_B = 2'd2} imm_sel_e;
   typedef enum logic [1:0] {PC_INC = 2'd0, PC_BR = 2'd1} pc_src_e;
   typedef enum logic [2:0] {C_ADDI, C_BNE, C_LW, C_SW, C_ILLEGAL} instr_class_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: opcode/funct3 to class and immediate format.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [31:0]  instr,
   output instr_class_e iclass,
   output imm_sel_e     imm_sel
);

   logic [4:0] opcode;
   logic [2:0] funct3;
   logic       unused_instr_bits;

   assign opcode = instr[6:2];
   assign funct3 = instr[14:12];
   // Only opcode and funct3 select the class; register and immediate fields are datapath business.
   assign unused_instr_bits = ^{instr[31:15], instr[11:7], instr[1:0]};

   always_comb begin
      iclass  = C_ILLEGAL;
      imm_sel = IMM_I;
      if (opcode == OP_OPIMM && funct3 == F3_ADDI) begin
         iclass = C_ADDI;
      end else if (opcode == OP_BRANCH && funct3 == F3_BNE) begin
         iclass  = C_BNE;
         imm_sel = IMM_B;
      end else if (opcode == OP_LOAD && funct3 == F3_WORD) begin
         iclass = C_LW;
      end else if (opcode == OP_STORE && funct3 == F3_WORD) begin
         iclass  = C_SW;
         imm_sel = IMM_S;
      end
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback over a shared memory port.
module mc_ctrl_fsm
   import ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        eq,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_src,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        reg_write,
   output logic [2:0]  alu_ctrl,
   output logic        alu_src,
   output logic [1:0]  imm_sel,
   output logic        result_src,
   output logic        retire,
   output logic        illegal,
   output logic [3:0]  state_o
);

   state_e       state_q, state_d;
   instr_class_e iclass;
   imm_sel_e     dec_imm_sel;

   ctrl_decode u_decode (
      .instr   (instr),
      .iclass  (iclass),
      .imm_sel (dec_imm_sel)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // Every output is forced low while rst is high, whatever state the register still holds.
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_src   = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PC_INC;
      reg_write  = 1'b0;
      alu_ctrl   = ALU_ADD;
      alu_src    = 1'b0;
      imm_sel    = IMM_I;
      result_src = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;
      state_o    = 4'd0;
      if (!rst) begin
         state_o = state_q;
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_we   = 1'b1;
                  pc_we   = 1'b1;
                  pc_src  = PC_INC;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               case (iclass)
                  C_ADDI:     state_d = S_EXEC_I;
                  C_BNE:      state_d = S_EXEC_B;
                  C_LW, C_SW: state_d = S_EXEC_M;
                  default:    state_d = S_TRAP;
               endcase
            end
            S_EXEC_I: begin
               alu_src = 1'b1;
               imm_sel = IMM_I;
               state_d = S_WB;
            end
            S_EXEC_B: begin
               alu_ctrl = ALU_SUB;
               imm_sel  = IMM_B;
               if (!eq) begin
                  pc_we  = 1'b1;
                  pc_src = PC_BR;
               end
               retire  = 1'b1;
               state_d = S_FETCH;
            end
            S_EXEC_M: begin
               alu_src = 1'b1;
               imm_sel = dec_imm_sel;
               state_d = (iclass == C_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               mem_req  = 1'b1;
               addr_src = 1'b1;
               if (mem_ready) state_d = S_WB;
            end
            S_MEM_WR: begin
               mem_req  = 1'b1;
               mem_we   = 1'b1;
               addr_src = 1'b1;
               if (mem_ready) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end
            S_WB: begin
               reg_write  = 1'b1;
               result_src = (iclass == C_LW);
               retire     = 1'b1;
               state_d    = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: state_d = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed vector bench for mc_ctrl_fsm: one table of per-cycle inputs/outputs plus a reset-in-store sequence.
module tb_mc_ctrl_fsm;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        eq;
   logic        mem_ready;
   logic        mem_req, mem_we, addr_src, ir_we, pc_we;
   logic [1:0]  pc_src;
   logic        reg_write;
   logic [2:0]  alu_ctrl;
   logic        alu_src;
   logic [1:0]  imm_sel;
   logic        result_src, retire, illegal;
   logic [3:0]  state_o;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] ADDI = 32'h0050_0093;
   localparam logic [31:0] BNE  = 32'h0020_9463;
   localparam logic [31:0] LW   = 32'h0000_A103;
   localparam logic [31:0] SW   = 32'h0020_A023;
   localparam logic [31:0] ILL  = 32'h0000_0033;

   typedef struct {
      logic        rst;
      logic [31:0] instr;
      logic        eq;
      logic        rdy;
      logic [20:0] exp;
   } vec_t;

   vec_t vecs[$];

   mc_ctrl_fsm dut (
      .clk        (clk),
      .rst        (rst),
      .instr      (instr),
      .eq         (eq),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .addr_src   (addr_src),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .reg_write  (reg_write),
      .alu_ctrl   (alu_ctrl),
      .alu_src    (alu_src),
      .imm_sel    (imm_sel),
      .result_src (result_src),
      .retire     (retire),
      .illegal    (illegal),
      .state_o    (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [20:0] actual();
      return {state_o, mem_req, mem_we, addr_src, ir_we, pc_we, pc_src, reg_write,
              alu_ctrl, alu_src, imm_sel, result_src, retire, illegal};
   endfunction

   // Argument order: st, req, we, asrc, irwe, pcwe, pcsrc, rw, alu, alusrc, imm, res, ret, ill
   task automatic add(input logic r, input logic [31:0] i, input logic e, input logic rd,
                      input logic [3:0] st, input logic req, input logic we, input logic asrc,
                      input logic irwe, input logic pcwe, input logic [1:0] pcs, input logic rw,
                      input logic [2:0] alu, input logic alus, input logic [1:0] imm,
                      input logic res, input logic ret, input logic ill);
      vec_t v;
      v.rst = r; v.instr = i; v.eq = e; v.rdy = rd;
      v.exp = {st, req, we, asrc, irwe, pcwe, pcs, rw, alu, alus, imm, res, ret, ill};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [20:0] got, input logic [20:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h (state got=%0d want=%0d)", name, got, want, got[20:17], want[20:17]);
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] i, input logic e, input logic rd);
      @(negedge clk);
      rst = r; instr = i; eq = e; mem_ready = rd;
      #1;
   endtask

   initial begin
      rst = 1'b1; instr = 32'h0; eq = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);

      // Reset holds everything low
      add(1, 0,    0, 1,  0, 0,0,0, 0,0,0, 0, 0,0,0, 0, 0,0);
      // addi: FETCH, DECODE, EXEC_I, WB
      add(0, ADDI, 0, 1,  0, 1,0,0, 1,1,0, 0, 0,0,0, 0, 0,0);
      add(0, ADDI, 0, 1,  1, 0,0,0, 0,0,0, 0, 0,0,0, 0, 0,0);
      add(0, ADDI, 0, 1,  2, 0,0,0, 0,0,0, 0, 0,1,0, 0, 0,0);
      add(0, ADDI, 0, 1,  7, 0,0,0, 0,0,0, 1, 0,0,0, 0, 1,0);
      // bne not-equal: branch taken
      add(0, BNE,  0, 1,  0, 1,0,0, 1,1,0, 0, 0,0,0, 0, 0,0);
      add(0, BNE,  0, 1,  1, 0,0,0, 0,0,0, 0, 0,0,0, 0, 0,0);
      add(0, BNE,  0, 1,  3, 0,0,0, 0,1,1, 0, 1,0,2, 0, 1,0);
      // bne equal: falls through
      add(0, BNE,  1, 1,  0, 1,0,0, 1,1,0, 0, 0,0,0, 0, 0,0);
      add(0, BNE,  1, 1,  1, 0,0,0, 0,0,0, 0, 0,0,0, 0, 0,0);
      add(0, BNE,  1, 1,  3, 0,0,0, 0,0,0, 0, 1,0,2, 0, 1,0);
      // lw with three wait cycles in MEM_RD
      add(0, LW,   0, 1,  0, 1,0,0, 1,1,0, 0, 0,0,0, 0, 0,0);
      add(0, LW,   0, 1,  1, 0,0,0, 0,0,0, 0, 0,0,0, 0, 0,0);
      add(0, LW,   0, 1,  4, 0,0,0, 0,0,0, 0, 0,1,0, 0, 0,0);
      for (int k = 0; k < 3; k++)
         add(0, LW, 0, 0,  5, 1,0,1, 0,0,0, 0, 0,0,0, 0, 0,0);
      add(0, LW,   0, 1,  5, 1,0,1, 0,0,0, 0, 0,0,0, 0, 0,0);
      add(0, LW,   0, 1,  7, 0,0,0, 0,0,0, 1, 0,0,0, 1, 1,0);
      // sw with one FETCH wait and one MEM_WR wait
      add(0, SW,   0, 0,  0, 1,0,0, 0,0,0, 0, 0,0,0, 0, 0,0);
      add(0, SW,   0, 1,  0, 1,0,0, 1,1,0, 0, 0,0,0, 0, 0,0);
      add(0, SW,   0, 1,  1, 0,0,0, 0,0,0, 0, 0,0,0, 0, 0,0);
      add(0, SW,   0, 1,  4, 0,0,0, 0,0,0, 0, 0,1,1, 0, 0,0);
      add(0, SW,   0, 0,  6, 1,1,1, 0,0,0, 0, 0,0,0, 0, 0,0);
      add(0, SW,   0, 1,  6, 1,1,1, 0,0,0, 0, 0,0,0, 0, 1,0);
      // illegal encoding traps; mem_ready toggles are ignored in TRAP
      add(0, ILL,  0, 1,  0, 1,0,0, 1,1,0, 0, 0,0,0, 0, 0,0);
      add(0, ILL,  0, 1,  1, 0,0,0, 0,0,0, 0, 0,0,0, 0, 0,0);
      for (int k = 0; k < 20; k++)
         add(0, ILL, k[0], !k[0],  8, 0,0,0, 0,0,0, 0, 0,0,0, 0, 0,1);
      add(1, ILL,  0, 1,  0, 0,0,0, 0,0,0, 0, 0,0,0, 0, 0,0);
      add(0, SW,   0, 0,  0, 1,0,0, 0,0,0, 0, 0,0,0, 0, 0,0);
      // sw into a stalled MEM_WR, followed by the hand-written reset sequence
      add(0, SW,   0, 1,  0, 1,0,0, 1,1,0, 0, 0,0,0, 0, 0,0);
      add(0, SW,   0, 1,  1, 0,0,0, 0,0,0, 0, 0,0,0, 0, 0,0);
      add(0, SW,   0, 1,  4, 0,0,0, 0,0,0, 0, 0,1,1, 0, 0,0);
      add(0, SW,   0, 0,  6, 1,1,1, 0,0,0, 0, 0,0,0, 0, 0,0);

      foreach (vecs[n]) begin
         drive(vecs[n].rst, vecs[n].instr, vecs[n].eq, vecs[n].rdy);
         check($sformatf("vec%0d", n), actual(), vecs[n].exp);
      end

      // rst during the stalled store: no strobes in the reset cycle
      drive(1, SW, 0, 0);
      check("rst_in_mem_wr", actual(), 21'h0);
      drive(1, SW, 0, 1);
      check("rst_held", actual(), 21'h0);
      drive(0, ADDI, 0, 0);
      check("refetch_state", {17'h0, state_o}, 21'd0);
      check("refetch_req", {18'h0, mem_req, mem_we, addr_src}, 21'b100);
      drive(0, ADDI, 0, 1);
      check("refetch_accept", {18'h0, ir_we, pc_we, retire}, 21'b110);
      drive(0, ADDI, 0, 1);
      check("refetch_decode", {17'h0, state_o}, 21'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
